// File: rtl/itcm_ctrl_pkg.sv
// Shared ITCM constants and types used by the ITCM controller and its response buffers.
package itcm_ctrl_pkg;

    localparam int ITCM_RAM_AW     = 12;
    localparam int ITCM_RAM_DW     = 32;
    localparam int ITCM_RAM_MW     = ITCM_RAM_DW / 8;
    localparam int ITCM_RAM_DP     = 1 << ITCM_RAM_AW;
    localparam int ITCM_STARVE_MAX = 4;

    // LIVE forwards the RAM output directly; HELD replays the captured word under backpressure.
    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_LIVE,
        RSP_HELD
    } rsp_state_e;

endpackage

// File: rtl/itcm_ctrl_rsp_buf.sv
// Per-port response stage: one outstanding response, delivered the cycle after accept,
// frozen in a hold register while the consumer stalls.
module itcm_rsp_buf
    import itcm_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         accept,
    input  logic         acc_ram,
    input  logic [W-1:0] acc_word,
    input  logic [W-1:0] ram_word,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_word,
    output logic         free
);

    rsp_state_e   state;
    rsp_state_e   state_nxt;
    logic         src_ram_q;
    logic [W-1:0] fixed_q;
    logic [W-1:0] hold_q;
    logic [W-1:0] live_word;

    assign live_word = src_ram_q ? ram_word : fixed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RSP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The RAM output is only trustworthy for one cycle, so a stalled LIVE word is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_ram_q <= 1'b0;
            fixed_q   <= '0;
            hold_q    <= '0;
        end else begin
            if (accept) begin
                src_ram_q <= acc_ram;
                fixed_q   <= acc_word;
            end
            if (state == RSP_LIVE && !rsp_ready) begin
                hold_q <= live_word;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RSP_IDLE: begin
                if (accept) state_nxt = RSP_LIVE;
            end
            RSP_LIVE, RSP_HELD: begin
                if (rsp_ready) state_nxt = accept ? RSP_LIVE : RSP_IDLE;
                else           state_nxt = RSP_HELD;
            end
            default: state_nxt = RSP_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state != RSP_IDLE);
        free      = (state == RSP_IDLE) || rsp_ready;
        rsp_word  = '0;
        case (state)
            RSP_LIVE: rsp_word = live_word;
            RSP_HELD: rsp_word = hold_q;
            default:  rsp_word = '0;
        endcase
    end

endmodule

// File: rtl/itcm_ctrl.sv
// ITCM front end: arbitrates IFU fetches and LSU accesses onto the single-port ITCM RAM,
// with LSU priority bounded by a fetch starvation counter.
module itcm_ctrl
    import itcm_ctrl_pkg::*;
#(
    parameter int AW         = ITCM_RAM_AW,
    parameter int DW         = ITCM_RAM_DW,
    parameter int MW         = ITCM_RAM_MW,
    parameter int STARVE_MAX = ITCM_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [31:0]   ifu_req_addr,
    output logic          ifu_rsp_valid,
    input  logic          ifu_rsp_ready,
    output logic [DW-1:0] ifu_rsp_rdata,
    output logic          ifu_rsp_err,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [31:0]   lsu_req_addr,
    input  logic          lsu_req_write,
    input  logic [DW-1:0] lsu_req_wdata,
    input  logic [MW-1:0] lsu_req_wmask,
    output logic          lsu_rsp_valid,
    input  logic          lsu_rsp_ready,
    output logic [DW-1:0] lsu_rsp_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic [MW-1:0] ram_wem,
    input  logic [DW-1:0] ram_dout
);

    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    logic           ifu_free;
    logic           lsu_free;
    logic           ifu_elig;
    logic           lsu_elig;
    logic           ifu_grant;
    logic           lsu_grant;
    logic           ifu_aligned;
    logic           starve_hit;
    logic [SCW-1:0] starve_cnt;
    logic [DW:0]    ifu_rsp_word;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^{ifu_req_addr[31:AW+2], lsu_req_addr[31:AW+2], lsu_req_addr[1:0]};

    assign ifu_aligned = (ifu_req_addr[1:0] == 2'b00);
    assign ifu_elig    = ifu_req_valid && ifu_free;
    assign lsu_elig    = lsu_req_valid && lsu_free;
    assign starve_hit  = (starve_cnt == STARVE_LIM);

    // Nothing is granted during reset, so a request presented on the reset edge is never performed.
    assign lsu_grant     = !rst && lsu_elig && !(ifu_elig && starve_hit);
    assign ifu_grant     = !rst && ifu_elig && (!lsu_elig || starve_hit);
    assign ifu_req_ready = ifu_grant;
    assign lsu_req_ready = lsu_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!ifu_elig || ifu_grant) begin
            starve_cnt <= '0;
        end else if (lsu_grant && !starve_hit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        ram_wem  = '0;
        if (lsu_grant) begin
            ram_we   = lsu_req_write;
            ram_addr = lsu_req_addr[AW+1:2];
            ram_din  = lsu_req_wdata;
            ram_wem  = lsu_req_wmask;
        end else if (ifu_grant && ifu_aligned) begin
            ram_addr = ifu_req_addr[AW+1:2];
        end
    end

    // The error flag rides as the top bit of the IFU response word so it is held with the data.
    itcm_rsp_buf #(.W(DW + 1)) u_ifu_rsp (
        .clk       (clk),
        .rst       (rst),
        .accept    (ifu_grant),
        .acc_ram   (ifu_aligned),
        .acc_word  ({!ifu_aligned, {DW{1'b0}}}),
        .ram_word  ({1'b0, ram_dout}),
        .rsp_valid (ifu_rsp_valid),
        .rsp_ready (ifu_rsp_ready),
        .rsp_word  (ifu_rsp_word),
        .free      (ifu_free)
    );

    assign ifu_rsp_err   = ifu_rsp_word[DW];
    assign ifu_rsp_rdata = ifu_rsp_word[DW-1:0];

    itcm_rsp_buf #(.W(DW)) u_lsu_rsp (
        .clk       (clk),
        .rst       (rst),
        .accept    (lsu_grant),
        .acc_ram   (!lsu_req_write),
        .acc_word  ({DW{1'b0}}),
        .ram_word  (ram_dout),
        .rsp_valid (lsu_rsp_valid),
        .rsp_ready (lsu_rsp_ready),
        .rsp_word  (lsu_rsp_rdata),
        .free      (lsu_free)
    );

endmodule

// File: tb/tb_itcm_ctrl.sv
// Directed bench for itcm_ctrl with a behavioural single-port RAM preloaded as 0xC0DE0000 | word.
module tb_itcm_ctrl;
    import itcm_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [31:0] ifu_req_addr, ifu_rsp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_write, lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
    logic [3:0]  lsu_req_wmask;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_din, ram_dout;
    logic [3:0]  ram_wem;
    logic [31:0] mem [0:ITCM_RAM_DP-1];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    itcm_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_rdata (ifu_rsp_rdata),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_write (lsu_req_write),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_wmask (lsu_req_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_wem       (ram_wem),
        .ram_dout      (ram_dout)
    );

    // Byte-masked write at the edge; reads every cycle with output valid the next cycle.
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 0; ifu_req_addr = 0; ifu_rsp_ready = 1;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_write = 0;
        lsu_req_wdata = 0; lsu_req_wmask = 0; lsu_rsp_ready = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        ifu_req_valid = 1; ifu_req_addr = 0; ifu_rsp_ready = 1;
        lsu_req_valid = 1; lsu_req_addr = 0; lsu_req_write = 1;
        lsu_req_wdata = 32'hFFFF_FFFF; lsu_req_wmask = 4'hF; lsu_rsp_ready = 1;
        step(); step(); #1;
        checks++; if (ifu_rsp_valid !== 1'b0) $display("[TB] FAIL reset_ifu_valid: got %b want 0", ifu_rsp_valid); else passes++;
        checks++; if (lsu_rsp_valid !== 1'b0) $display("[TB] FAIL reset_lsu_valid: got %b want 0", lsu_rsp_valid); else passes++;
        checks++; if (ifu_rsp_rdata !== 32'h0) $display("[TB] FAIL reset_ifu_rdata: got %h want 0", ifu_rsp_rdata); else passes++;
        checks++; if (lsu_rsp_rdata !== 32'h0) $display("[TB] FAIL reset_lsu_rdata: got %h want 0", lsu_rsp_rdata); else passes++;
        checks++; if (ifu_rsp_err !== 1'b0) $display("[TB] FAIL reset_ifu_err: got %b want 0", ifu_rsp_err); else passes++;
        checks++; if (ifu_req_ready !== 1'b0) $display("[TB] FAIL reset_ifu_ready: got %b want 0", ifu_req_ready); else passes++;
        checks++; if (lsu_req_ready !== 1'b0) $display("[TB] FAIL reset_lsu_ready: got %b want 0", lsu_req_ready); else passes++;
        checks++; if (ram_we !== 1'b0) $display("[TB] FAIL reset_ram_we: got %b want 0", ram_we); else passes++;
        idle_inputs();
        rst = 0;
        step();
    endtask

    task automatic test_back_to_back();
        ifu_req_valid = 1; ifu_req_addr = 32'h0; #1;
        checks++; if (ifu_req_ready !== 1'b1) $display("[TB] FAIL b2b_ready0: got %b want 1", ifu_req_ready); else passes++;
        step();
        ifu_req_addr = 32'h4; #1;
        checks++; if (ifu_rsp_valid !== 1'b1) $display("[TB] FAIL b2b_valid0: got %b want 1", ifu_rsp_valid); else passes++;
        checks++; if (ifu_rsp_rdata !== 32'hC0DE_0000) $display("[TB] FAIL b2b_rdata0: got %h want c0de0000", ifu_rsp_rdata); else passes++;
        checks++; if (ifu_req_ready !== 1'b1 || ram_addr !== 12'd1) $display("[TB] FAIL b2b_accept1: got ready %b addr %h want 1 001", ifu_req_ready, ram_addr); else passes++;
        step();
        ifu_req_valid = 0; #1;
        checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== 32'hC0DE_0001) $display("[TB] FAIL b2b_rsp1: got %b %h want 1 c0de0001", ifu_rsp_valid, ifu_rsp_rdata); else passes++;
        step();
        checks++; if (ifu_rsp_valid !== 1'b0) $display("[TB] FAIL b2b_drain: got %b want 0", ifu_rsp_valid); else passes++;
    endtask

    task automatic test_lsu_write_read();
        lsu_req_valid = 1; lsu_req_write = 1; lsu_req_addr = 32'h10;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'b0011; #1;
        checks++; if (lsu_req_ready !== 1'b1 || ram_we !== 1'b1 || ram_wem !== 4'b0011 || ram_addr !== 12'd4)
            $display("[TB] FAIL wr_drive: got ready %b we %b wem %b addr %h want 1 1 0011 004", lsu_req_ready, ram_we, ram_wem, ram_addr); else passes++;
        step();
        lsu_req_write = 0; lsu_req_wmask = 0; #1;
        checks++; if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'h0) $display("[TB] FAIL wr_rsp: got %b %h want 1 0", lsu_rsp_valid, lsu_rsp_rdata); else passes++;
        step();
        lsu_req_valid = 0; #1;
        checks++; if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'hC0DE_BEEF) $display("[TB] FAIL rd_after_wr: got %b %h want 1 c0debeef", lsu_rsp_valid, lsu_rsp_rdata); else passes++;
        step();
        idle_inputs();
    endtask

    task automatic test_ifu_hold();
        ifu_req_valid = 1; ifu_req_addr = 32'h8; ifu_rsp_ready = 0;
        step();
        ifu_req_addr = 32'hC; lsu_req_valid = 1; lsu_req_addr = 32'h20; #1;
        checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== 32'hC0DE_0002) $display("[TB] FAIL hold_live: got %b %h want 1 c0de0002", ifu_rsp_valid, ifu_rsp_rdata); else passes++;
        checks++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b1) $display("[TB] FAIL hold_busy_grant: got ifu %b lsu %b want 0 1", ifu_req_ready, lsu_req_ready); else passes++;
        step();
        ifu_req_valid = 0; lsu_req_addr = 32'h24; #1;
        checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== 32'hC0DE_0002) $display("[TB] FAIL hold_c2: got %b %h want 1 c0de0002", ifu_rsp_valid, ifu_rsp_rdata); else passes++;
        checks++; if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'hC0DE_0008) $display("[TB] FAIL hold_lsu0: got %b %h want 1 c0de0008", lsu_rsp_valid, lsu_rsp_rdata); else passes++;
        step();
        lsu_req_addr = 32'h28; #1;
        checks++; if (ifu_rsp_rdata !== 32'hC0DE_0002) $display("[TB] FAIL hold_c3: got %h want c0de0002", ifu_rsp_rdata); else passes++;
        checks++; if (lsu_rsp_rdata !== 32'hC0DE_0009) $display("[TB] FAIL hold_lsu1: got %h want c0de0009", lsu_rsp_rdata); else passes++;
        step();
        lsu_req_valid = 0; ifu_rsp_ready = 1; #1;
        checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== 32'hC0DE_0002 || ifu_rsp_err !== 1'b0)
            $display("[TB] FAIL hold_release: got %b %h %b want 1 c0de0002 0", ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err); else passes++;
        checks++; if (lsu_rsp_rdata !== 32'hC0DE_000A) $display("[TB] FAIL hold_lsu2: got %h want c0de000a", lsu_rsp_rdata); else passes++;
        step();
        checks++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) $display("[TB] FAIL hold_once: got ifu %b lsu %b want 0 0", ifu_rsp_valid, lsu_rsp_valid); else passes++;
        idle_inputs();
    endtask

    task automatic test_starvation();
        int ifu_hs = 0;
        int lsu_hs = 0;
        int lsu_bad = 0;
        logic exp_ifu;
        ifu_req_valid = 1; ifu_req_addr = 32'h0;
        lsu_req_valid = 1; lsu_req_addr = 32'h4;
        for (int i = 0; i < 20; i++) begin
            #1;
            exp_ifu = ((i % 5) == 4);
            checks++; if (ifu_req_ready !== exp_ifu || lsu_req_ready !== !exp_ifu)
                $display("[TB] FAIL starve_grant c%0d: got ifu %b lsu %b want %b %b", i, ifu_req_ready, lsu_req_ready, exp_ifu, !exp_ifu); else passes++;
            if (ifu_rsp_valid === 1'b1) ifu_hs++;
            if (lsu_rsp_valid === 1'b1) begin
                lsu_hs++;
                if (lsu_rsp_rdata !== 32'hC0DE_0001) lsu_bad++;
            end
            step();
        end
        idle_inputs(); #1;
        if (ifu_rsp_valid === 1'b1) ifu_hs++;
        if (lsu_rsp_valid === 1'b1) lsu_hs++;
        checks++; if (ifu_hs !== 4) $display("[TB] FAIL starve_ifu_count: got %0d want 4", ifu_hs); else passes++;
        checks++; if (lsu_hs !== 16) $display("[TB] FAIL starve_lsu_count: got %0d want 16", lsu_hs); else passes++;
        checks++; if (lsu_bad !== 0) $display("[TB] FAIL starve_lsu_data: got %0d bad words want 0", lsu_bad); else passes++;
        step();
    endtask

    task automatic test_misaligned();
        ifu_req_valid = 1; ifu_req_addr = 32'h6; #1;
        checks++; if (ifu_req_ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 12'd0 || ram_wem !== 4'd0)
            $display("[TB] FAIL mis_drive: got ready %b we %b addr %h wem %b want 1 0 000 0000", ifu_req_ready, ram_we, ram_addr, ram_wem); else passes++;
        step();
        ifu_req_valid = 0; #1;
        checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_err !== 1'b1 || ifu_rsp_rdata !== 32'h0)
            $display("[TB] FAIL mis_rsp: got %b err %b %h want 1 1 0", ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata); else passes++;
        step();
        checks++; if (ifu_rsp_valid !== 1'b0 || ifu_rsp_err !== 1'b0) $display("[TB] FAIL mis_drain: got %b err %b want 0 0", ifu_rsp_valid, ifu_rsp_err); else passes++;
    endtask

    task automatic test_reset_mid();
        ifu_req_valid = 1; ifu_req_addr = 32'h0; ifu_rsp_ready = 0;
        lsu_req_valid = 1; lsu_req_addr = 32'h4; lsu_rsp_ready = 0;
        step();
        #1;
        checks++; if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) $display("[TB] FAIL rmid_grant: got ifu %b lsu %b want 1 0", ifu_req_ready, lsu_req_ready); else passes++;
        step();
        rst = 1; ifu_req_valid = 0;
        lsu_req_valid = 1; lsu_req_write = 1; lsu_req_addr = 32'h0; lsu_req_wdata = 32'h0; lsu_req_wmask = 4'hF; #1;
        checks++; if (ifu_rsp_valid !== 1'b1 || lsu_rsp_valid !== 1'b1) $display("[TB] FAIL rmid_pending: got ifu %b lsu %b want 1 1", ifu_rsp_valid, lsu_rsp_valid); else passes++;
        checks++; if (lsu_req_ready !== 1'b0 || ram_we !== 1'b0) $display("[TB] FAIL rmid_block: got ready %b we %b want 0 0", lsu_req_ready, ram_we); else passes++;
        step();
        checks++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) $display("[TB] FAIL rmid_drop: got ifu %b lsu %b want 0 0", ifu_rsp_valid, lsu_rsp_valid); else passes++;
        idle_inputs(); rst = 0;
        ifu_req_valid = 1; ifu_req_addr = 32'h0; #1;
        checks++; if (ifu_req_ready !== 1'b1) $display("[TB] FAIL rmid_reaccept: got %b want 1", ifu_req_ready); else passes++;
        step();
        ifu_req_valid = 0; #1;
        checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== 32'hC0DE_0000) $display("[TB] FAIL rmid_read: got %b %h want 1 c0de0000", ifu_rsp_valid, ifu_rsp_rdata); else passes++;
        step();
    endtask

    initial begin
        for (int i = 0; i < ITCM_RAM_DP; i++) mem[i] <= 32'hC0DE_0000 | i;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_lsu_write_read();
        test_ifu_hold();
        test_starvation();
        test_misaligned();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
